// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the register-file instruction sequencer.
package regfile_ctrl_pkg;

    typedef enum logic [2:0] {
        StWait,
        StDecode,
        StWriteImm,
        StGetA,
        StGetB,
        StAlu,
        StWriteReg,
        StStatus
    } state_e;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_CMP    = 2'b01;
    localparam logic [1:0] OP_AND    = 2'b10;
    localparam logic [1:0] OP_MVN    = 2'b11;
    localparam logic [1:0] OP_MOVIMM = 2'b10;
    localparam logic [1:0] OP_MOVREG = 2'b00;

    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b10;

    // Decoded instruction fields.
    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  op;
        logic [2:0]  rn;
        logic [2:0]  rd;
        logic [1:0]  shift;
        logic [2:0]  rm;
        logic [15:0] sximm8;
    } instr_t;

    // Per-state control strobes, held in a register so outputs are glitch-free.
    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] vsel;
        logic       bad;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{w: 1'b1, default: '0};

    function automatic logic is_supported(input logic [2:0] opcode, input logic [1:0] op);
        return ((opcode == OPC_MOV) && ((op == OP_MOVIMM) || (op == OP_MOVREG))) ||
               (opcode == OPC_ALU);
    endfunction

endpackage

// File: rtl/regfile_ctrl_instr_dec.sv
// Field extraction and immediate sign extension for a 16-bit instruction word.
module instr_dec
    import regfile_ctrl_pkg::*;
(
    input  logic [15:0] ir_i,
    output instr_t      dec_o
);

    // Pure wiring of instruction fields plus sign extension of imm8.
    always_comb begin
        dec_o.opcode = ir_i[15:13];
        dec_o.op     = ir_i[12:11];
        dec_o.rn     = ir_i[10:8];
        dec_o.rd     = ir_i[7:5];
        dec_o.shift  = ir_i[4:3];
        dec_o.rm     = ir_i[2:0];
        dec_o.sximm8 = {{8{ir_i[7]}}, ir_i[7:0]};
    end

endmodule

// File: rtl/regfile_ctrl.sv
// Instruction sequencer driving the 8x16 register file and ALU datapath strobes.
module regfile_ctrl
    import regfile_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  vsel,
    output logic [1:0]  aluop,
    output logic [1:0]  shift,
    output logic [15:0] sximm8,
    output logic        bad
);

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    ctrl_t       ctrl_q, ctrl_d;
    instr_t      dec;
    logic        is_cmp;
    logic        a_is_zero;

    instr_dec u_instr_dec (
        .ir_i  (ir_q),
        .dec_o (dec)
    );

    assign is_cmp    = (dec.opcode == OPC_ALU) && (dec.op == OP_CMP);
    // MOV reg and MVN pass only the B operand through the ALU.
    assign a_is_zero = (dec.opcode == OPC_MOV) ||
                       ((dec.opcode == OPC_ALU) && (dec.op == OP_MVN));

    // Next-state and instruction latch selection.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        unique case (state_q)
            StWait: begin
                if (s) begin
                    ir_d    = in;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = StWait;
                if (dec.opcode == OPC_MOV) begin
                    if (dec.op == OP_MOVIMM) begin
                        state_d = StWriteImm;
                    end else if (dec.op == OP_MOVREG) begin
                        state_d = StGetB;
                    end
                end else if (dec.opcode == OPC_ALU) begin
                    unique case (dec.op)
                        OP_ADD, OP_AND, OP_CMP: state_d = StGetA;
                        OP_MVN:                 state_d = StGetB;
                        default:                state_d = StWait;
                    endcase
                end
            end
            StGetA:     state_d = StGetB;
            StGetB:     state_d = is_cmp ? StStatus : StAlu;
            StAlu:      state_d = StWriteReg;
            StWriteImm: state_d = StWait;
            StWriteReg: state_d = StWait;
            StStatus:   state_d = StWait;
            default:    state_d = StWait;
        endcase
    end

    // Moore outputs for the state being entered. Only DECODE is entered while ir is
    // being loaded, so it decodes ir_d; every later state sees a settled ir_q.
    always_comb begin
        ctrl_d = '0;
        unique case (state_d)
            StWait: ctrl_d.w = 1'b1;
            StDecode: ctrl_d.bad = !is_supported(ir_d[15:13], ir_d[12:11]);
            StWriteImm: begin
                ctrl_d.write    = 1'b1;
                ctrl_d.writenum = dec.rn;
                ctrl_d.vsel     = VSEL_IMM;
            end
            StGetA: begin
                ctrl_d.readnum = dec.rn;
                ctrl_d.loada   = 1'b1;
            end
            StGetB: begin
                ctrl_d.readnum = dec.rm;
                ctrl_d.loadb   = 1'b1;
            end
            StAlu: begin
                ctrl_d.loadc = 1'b1;
                ctrl_d.asel  = a_is_zero;
                ctrl_d.bsel  = 1'b0;
            end
            StWriteReg: begin
                ctrl_d.write    = 1'b1;
                ctrl_d.writenum = dec.rd;
                ctrl_d.vsel     = VSEL_C;
            end
            StStatus: ctrl_d.loads = 1'b1;
            default: ctrl_d = '0;
        endcase
    end

    // State, instruction register and registered control outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StWait;
            ir_q    <= '0;
            ctrl_q  <= CTRL_RESET;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign w        = ctrl_q.w;
    assign readnum  = ctrl_q.readnum;
    assign writenum = ctrl_q.writenum;
    assign write    = ctrl_q.write;
    assign loada    = ctrl_q.loada;
    assign loadb    = ctrl_q.loadb;
    assign loadc    = ctrl_q.loadc;
    assign loads    = ctrl_q.loads;
    assign asel     = ctrl_q.asel;
    assign bsel     = ctrl_q.bsel;
    assign vsel     = ctrl_q.vsel;
    assign bad      = ctrl_q.bad;
    assign aluop    = dec.op;
    assign shift    = dec.shift;
    assign sximm8   = dec.sximm8;

endmodule
